task_graph_streamer: RTL and testbench

- Upstream feeder for task_mapper.
- Holds one application's NUM_V x NUM_V task-graph adjacency matrix (edge weights; 0 = no edge) in a local register file.
- On start, streams the matrix row-major to task_mapper as task_array/row/col/root_task/app_end, repeated for a programmed number of applications.
- Replaces the behavioural stimulus loop with synthesizable RTL at the exact cadence task_mapper expects.

---
 rtl/task_graph_streamer.sv | 156 +++++++++++++++
 tb/tb_task_graph_streamer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/task_graph_streamer.sv
// Streams a stored NUM_V x NUM_V task graph row-major to task_mapper, once per application.
// First entry appears 1 cycle after start; each entry is held 2 cycles; there is no backpressure.
module task_graph_streamer #(
   parameter int NUM_V  = 3,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 32,
   parameter int APP_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_row,
   input  logic [IDX_W-1:0]  wr_col,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic [APP_W-1:0]  num_apps,
   output logic [DATA_W-1:0] task_array,
   output logic [IDX_W-1:0]  row,
   output logic [IDX_W-1:0]  col,
   output logic              root_task,
   output logic              app_end,
   output logic              busy,
   output logic              done,
   output logic              wr_dropped
);

   localparam int RW    = (NUM_V > 1) ? $clog2(NUM_V) : 1;
   localparam int CNT_W = $clog2(NUM_V * NUM_V + 1);
   localparam logic [RW-1:0]    LAST = RW'(NUM_V - 1);
   localparam logic [IDX_W-1:0] NV   = IDX_W'(NUM_V);

   typedef enum logic [2:0] {IDLE, EMIT0, EMIT1, GAP0, END, GAP1, DONE} state_t;

   state_t             state, state_nxt;
   logic [DATA_W-1:0]  mat [NUM_V][NUM_V];
   logic [RW-1:0]      r_idx, c_idx, r_nxt, c_nxt;
   logic [APP_W-1:0]   apps_left, apps_nxt;
   logic [CNT_W-1:0]   nz_cnt, cnt_nxt;
   logic [DATA_W-1:0]  ta_nxt;
   logic [IDX_W-1:0]   row_nxt, col_nxt;
   logic               root_nxt, load, wr_ok;

   assign wr_ok = (state == IDLE) && (wr_row < NV) && (wr_col < NV);

   always_comb begin
      state_nxt = state;
      r_nxt     = r_idx;
      c_nxt     = c_idx;
      apps_nxt  = apps_left;
      cnt_nxt   = nz_cnt;
      ta_nxt    = '0;
      row_nxt   = '0;
      col_nxt   = '0;
      root_nxt  = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: if (start) begin
            if (num_apps == '0) begin
               state_nxt = DONE;
            end else begin
               state_nxt = EMIT0;
               apps_nxt  = num_apps;
               r_nxt     = '0;
               c_nxt     = '0;
               cnt_nxt   = '0;
               load      = 1'b1;
            end
         end
         EMIT0: begin
            state_nxt = EMIT1;
            ta_nxt    = task_array;
            row_nxt   = row;
            col_nxt   = col;
            root_nxt  = root_task;
         end
         EMIT1: begin
            if (r_idx == LAST && c_idx == LAST) begin
               state_nxt = GAP0;
            end else begin
               state_nxt = EMIT0;
               load      = 1'b1;
               if (c_idx == LAST) begin
                  c_nxt = '0;
                  r_nxt = r_idx + 1'b1;
               end else begin
                  c_nxt = c_idx + 1'b1;
               end
            end
         end
         GAP0: state_nxt = END;
         END:  state_nxt = GAP1;
         GAP1: begin
            if (apps_left > APP_W'(1)) begin
               state_nxt = EMIT0;
               apps_nxt  = apps_left - 1'b1;
               r_nxt     = '0;
               c_nxt     = '0;
               cnt_nxt   = '0;
               load      = 1'b1;
            end else begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // root is the entry that moves the per-application nonzero count from 0 to 1
      if (load) begin
         ta_nxt  = mat[r_nxt][c_nxt];
         row_nxt = IDX_W'(r_nxt);
         col_nxt = IDX_W'(c_nxt);
         if (ta_nxt != '0) begin
            root_nxt = (cnt_nxt == '0);
            if (cnt_nxt != '1) cnt_nxt = cnt_nxt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         r_idx      <= '0;
         c_idx      <= '0;
         apps_left  <= '0;
         nz_cnt     <= '0;
         task_array <= '0;
         row        <= '0;
         col        <= '0;
         root_task  <= 1'b0;
         app_end    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         wr_dropped <= 1'b0;
         for (int i = 0; i < NUM_V; i++)
            for (int j = 0; j < NUM_V; j++)
               mat[i][j] <= '0;
      end else begin
         state      <= state_nxt;
         r_idx      <= r_nxt;
         c_idx      <= c_nxt;
         apps_left  <= apps_nxt;
         nz_cnt     <= cnt_nxt;
         task_array <= ta_nxt;
         row        <= row_nxt;
         col        <= col_nxt;
         root_task  <= root_nxt;
         app_end    <= (state_nxt == END);
         busy       <= (state_nxt == EMIT0) || (state_nxt == EMIT1) || (state_nxt == GAP0)
                       || (state_nxt == END) || (state_nxt == GAP1);
         done       <= (state_nxt == DONE);
         if (wr_en && !wr_ok) wr_dropped <= 1'b1;
         if (wr_ok && wr_en) mat[wr_row[RW-1:0]][wr_col[RW-1:0]] <= wr_data;
      end
   end

endmodule

// File: tb/tb_task_graph_streamer.sv
// Scoreboard bench for task_graph_streamer: per-cycle expected outputs are queued at start and popped each cycle.
module tb_task_graph_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_row, wr_col, wr_data;
   logic        start;
   logic [15:0] num_apps;
   logic [31:0] task_array, row, col;
   logic        root_task, app_end, busy, done, wr_dropped;

   typedef struct packed {
      logic [31:0] ta;
      logic [31:0] row;
      logic [31:0] col;
      logic        root;
      logic        aend;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m [3][3];
   int          checks = 0;
   int          failures = 0;

   task_graph_streamer dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_data(wr_data), .start(start), .num_apps(num_apps), .task_array(task_array),
      .row(row), .col(col), .root_task(root_task), .app_end(app_end), .busy(busy),
      .done(done), .wr_dropped(wr_dropped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ta"}, task_array, 0);
      check({tag, "_row"}, row, 0);
      check({tag, "_col"}, col, 0);
      check({tag, "_root"}, root_task, 0);
      check({tag, "_aend"}, app_end, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_wrdrop"}, wr_dropped, 0);
   endtask

   // One clock: compare the queued expectation at the negedge, then step to just after the posedge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
         e = q.pop_front();
         check("task_array", task_array, e.ta);
         check("row", row, e.row);
         check("col", col, e.col);
         check("root_task", root_task, e.root);
         check("app_end", app_end, e.aend);
         check("busy", busy, e.busy);
         check("done", done, e.done);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      while (q.size() > 0) cycle();
   endtask

   task automatic push_stream(input int n);
      exp_t e;
      bit   seen;
      q.push_back('0);
      for (int a = 0; a < n; a++) begin
         seen = 1'b0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
               e      = '0;
               e.ta   = m[r][c];
               e.row  = r;
               e.col  = c;
               e.busy = 1'b1;
               e.root = (m[r][c] != 0) && !seen;
               if (m[r][c] != 0) seen = 1'b1;
               q.push_back(e);
               q.push_back(e);
            end
         e = '0; e.busy = 1'b1;
         q.push_back(e);
         e.aend = 1'b1;
         q.push_back(e);
         e.aend = 1'b0;
         q.push_back(e);
      end
      e = '0; e.done = 1'b1;
      q.push_back(e);
      q.push_back('0);
   endtask

   task automatic start_stream(input int n);
      push_stream(n);
      num_apps = 16'(n);
      start    = 1'b1;
      cycle();
      start    = 1'b0;
   endtask

   task automatic write(input int r, input int c, input int d);
      wr_en   = 1'b1;
      wr_row  = r;
      wr_col  = c;
      wr_data = d;
      cycle();
      wr_en   = 1'b0;
      if (r < 3 && c < 3) m[r][c] = d;
   endtask

   task automatic load_matrix();
      write(0, 1, 5);
      write(0, 2, 7);
      write(1, 0, 5);
      write(1, 1, 6);
      write(2, 0, 7);
   endtask

   task automatic clear_model();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            m[r][c] = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_row = 0; wr_col = 0; wr_data = 0;
      start = 1'b0; num_apps = 0;
      clear_model();
      #1;
      check_all_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      cycle();

      load_matrix();
      check("wr_dropped_clean", wr_dropped, 0);

      start_stream(1);
      drain();

      start_stream(3);
      drain();

      // Writes and starts during streaming must be ignored.
      start_stream(1);
      repeat (4) cycle();
      wr_en = 1'b1; wr_row = 0; wr_col = 0; wr_data = 9;
      start = 1'b1; num_apps = 2;
      cycle();
      wr_en = 1'b0; start = 1'b0;
      drain();
      check("wr_dropped_busy", wr_dropped, 1);
      start_stream(1);
      drain();

      start_stream(0);
      drain();

      rst = 1'b1;
      #1;
      clear_model();
      check_all_zero("reset2");
      @(posedge clk); #1;
      rst = 1'b0;
      write(3, 0, 4);
      check("wr_dropped_range", wr_dropped, 1);
      start_stream(1);
      drain();

      // Async reset in the middle of the fourth entry of a two-application run.
      load_matrix();
      start_stream(2);
      repeat (6) cycle();
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      clear_model();
      check_all_zero("reset_mid");
      @(posedge clk); #1;
      rst = 1'b0;
      cycle();
      start_stream(1);
      drain();
      check("wr_dropped_final", wr_dropped, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
